// File: rtl/dqs_dly_scan.sv
// DQS delay scan: steps the fine delay pipe through a code range, takes a
// majority vote of dqs_sample at each code and records the first transition.
module dqs_dly_scan #(
  parameter int DLY_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 dly_ready,
  input  logic [DLY_WIDTH-1:0] dly_first,
  input  logic [DLY_WIDTH-1:0] dly_last,
  input  logic [DLY_WIDTH-1:0] dly_step,
  input  logic                 dqs_sample,
  output logic [DLY_WIDTH-1:0] dly_out,
  output logic                 ld_dly,
  output logic                 set_dly,
  output logic                 busy,
  output logic                 done,
  output logic                 edge_found,
  output logic [DLY_WIDTH-1:0] edge_dly,
  output logic [7:0]           ones_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_APPLY    = 3'd3;
  localparam logic [2:0] S_SETTLE   = 3'd4;
  localparam logic [2:0] S_SAMPLE   = 3'd5;
  localparam logic [2:0] S_EVAL     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [15:0] SAMPLE_LAST = 16'(NUM_SAMPLES - 1);
  localparam logic [8:0]  MAJ_THRESH  = 9'(NUM_SAMPLES);

  logic [2:0]           state_q, state_d;
  logic [DLY_WIDTH-1:0] cur_q, cur_d;
  logic [DLY_WIDTH-1:0] last_q, last_d;
  logic [DLY_WIDTH-1:0] step_q, step_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [7:0]           count_q, count_d;
  logic                 prev_maj_q, prev_maj_d;
  logic                 first_pt_q, first_pt_d;
  logic [DLY_WIDTH-1:0] dly_out_q, dly_out_d;
  logic                 ld_dly_q, ld_dly_d;
  logic                 set_dly_q, set_dly_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 edge_found_q, edge_found_d;
  logic [DLY_WIDTH-1:0] edge_dly_q, edge_dly_d;
  logic [7:0]           ones_cnt_q, ones_cnt_d;
  logic                 maj_s;
  logic [DLY_WIDTH:0]   next_cur_s;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    count_d      = count_q;
    prev_maj_d   = prev_maj_q;
    first_pt_d   = first_pt_q;
    edge_found_d = edge_found_q;
    edge_dly_d   = edge_dly_q;
    ones_cnt_d   = ones_cnt_q;
    maj_s        = ({count_q, 1'b0} > MAJ_THRESH);
    next_cur_s   = {1'b0, cur_q} + {1'b0, step_q};

    // abort overrides every transition, including a simultaneous start
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_d        = dly_first;
            last_d       = dly_last;
            step_d       = (dly_step == '0) ? DLY_WIDTH'(1) : dly_step;
            edge_found_d = 1'b0;
            edge_dly_d   = '0;
            first_pt_d   = 1'b1;
            state_d      = S_WAIT_RDY;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT_RDY: begin
          state_d = dly_ready ? S_LOAD : S_WAIT_RDY;
        end
        S_LOAD: begin
          cnt_d   = 16'd0;
          count_d = 8'd0;
          state_d = dly_ready ? S_APPLY : S_WAIT_RDY;
        end
        S_APPLY: begin
          if (!dly_ready) begin
            state_d = S_WAIT_RDY;
          end else begin
            state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!dly_ready) begin
            state_d = S_WAIT_RDY;
          end else if (cnt_q == SETTLE_LAST) begin
            cnt_d   = 16'd0;
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_SAMPLE: begin
          if (!dly_ready) begin
            state_d = S_WAIT_RDY;
          end else begin
            count_d = count_q + {7'd0, dqs_sample};
            if (cnt_q == SAMPLE_LAST) begin
              state_d = S_EVAL;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        S_EVAL: begin
          ones_cnt_d = count_q;
          if (!first_pt_q && (maj_s != prev_maj_q) && !edge_found_q) begin
            edge_found_d = 1'b1;
            edge_dly_d   = cur_q;
          end else begin
            edge_found_d = edge_found_q;
          end
          prev_maj_d = maj_s;
          first_pt_d = 1'b0;
          // cur>=last also terminates the first>last case after one point
          if ((cur_q >= last_q) || (next_cur_s > {1'b0, last_q}) || next_cur_s[DLY_WIDTH]) begin
            state_d = S_DONE;
          end else begin
            cur_d   = next_cur_s[DLY_WIDTH-1:0];
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // outputs are registered copies of what the next state implies
    ld_dly_d  = (state_d == S_LOAD);
    set_dly_d = (state_d == S_APPLY);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    dly_out_d = (state_d == S_LOAD) ? cur_d : dly_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      step_q       <= '0;
      cnt_q        <= 16'd0;
      count_q      <= 8'd0;
      prev_maj_q   <= 1'b0;
      first_pt_q   <= 1'b0;
      dly_out_q    <= '0;
      ld_dly_q     <= 1'b0;
      set_dly_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      edge_found_q <= 1'b0;
      edge_dly_q   <= '0;
      ones_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      prev_maj_q   <= prev_maj_d;
      first_pt_q   <= first_pt_d;
      dly_out_q    <= dly_out_d;
      ld_dly_q     <= ld_dly_d;
      set_dly_q    <= set_dly_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      edge_found_q <= edge_found_d;
      edge_dly_q   <= edge_dly_d;
      ones_cnt_q   <= ones_cnt_d;
    end
  end

  assign dly_out    = dly_out_q;
  assign ld_dly     = ld_dly_q;
  assign set_dly    = set_dly_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign edge_found = edge_found_q;
  assign edge_dly   = edge_dly_q;
  assign ones_cnt   = ones_cnt_q;

endmodule

// File: doc/dqs_dly_scan.md
DQS_DLY_SCAN -- requirements
Module: dqs_dly_scan

Interface
REQ-001 Parameter DLY_WIDTH, default 8: width of the delay code driven to the fine delay pipe.
REQ-002 Parameter SETTLE_CYCLES, default 4: clk cycles waited after applying a delay, before sampling starts.
REQ-003 Parameter NUM_SAMPLES, default 16: dqs_sample observations per delay point; range 1..255.
REQ-004 The block has one clock; reset is asynchronous and active-low, and the ports are named clk and rst.
REQ-005 clk  input  1  clock for all logic; this is the clk_div domain of the delay pipe.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request that begins a scan; accepted only in IDLE.
REQ-008 abort  input  1  level input; ends any scan.
REQ-009 dly_ready  input  1  IDELAYCTRL ready flag.
REQ-010 dly_first, dly_last  input  DLY_WIDTH  scan bounds, captured on start.
REQ-011 dly_step  input  DLY_WIDTH  scan increment, captured on start; 0 is treated as 1.
REQ-012 dqs_sample  input  1  received DQS level, already synchronous to clk.
REQ-013 dly_out  output  DLY_WIDTH  delay code for the fine delay pipe.
REQ-014 ld_dly, set_dly  output  1  one-cycle load and apply strobes for the fine delay pipe.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at scan completion.
REQ-017 edge_found  output  1  a majority transition was found during the last scan.
REQ-018 edge_dly  output  DLY_WIDTH  delay code at the first transition.
REQ-019 ones_cnt  output  8  ones count for the most recently evaluated point.

Function
REQ-020 The state machine SHALL have the states IDLE, WAIT_RDY, LOAD, APPLY, SETTLE, SAMPLE, EVAL and DONE.
REQ-021 IDLE: when start is high, capture first, last and step, set cur=first, clear edge_found and edge_dly, and go to WAIT_RDY.
REQ-022 WAIT_RDY: stay while dly_ready=0; go to LOAD on the cycle after dly_ready=1 is seen.
REQ-023 LOAD: drive dly_out=cur and ld_dly=1 for exactly one cycle, then go to APPLY.
REQ-024 APPLY: set_dly=1 for exactly one cycle, then go to SETTLE; dly_out SHALL hold cur from LOAD until the next LOAD.
REQ-025 SETTLE: stay exactly SETTLE_CYCLES cycles; if SETTLE_CYCLES=0, go directly to SAMPLE.
REQ-026 SAMPLE: stay exactly NUM_SAMPLES cycles and add dqs_sample to an 8-bit count each cycle.
REQ-027 EVAL (one cycle): ones_cnt<=count; maj=(2*count > NUM_SAMPLES), computed 9 bits wide; a tie counts as 0.
REQ-028 EVAL: if the point is not the first and maj != prev_maj and edge_found=0, set edge_found=1 and edge_dly=cur; then prev_maj<=maj.
REQ-029 EVAL: next=cur+step, computed DLY_WIDTH+1 bits wide; if cur>=last or next>last or next overflows, go to DONE; otherwise cur<=next and go to LOAD.
REQ-030 If first>last, the block SHALL scan exactly one point, first, and then finish.
REQ-031 DONE: done=1 for one cycle, then go to IDLE; edge_found, edge_dly and ones_cnt hold until the next start.
REQ-032 If dly_ready falls in LOAD, APPLY, SETTLE or SAMPLE, the block SHALL discard that point's count and go to WAIT_RDY, then rerun the same cur.
REQ-033 If abort=1 in any state, the next state SHALL be IDLE, no done pulse SHALL occur, and the results keep their partial values.
REQ-034 When start and abort are high in the same cycle, abort wins.
REQ-035 A start received while busy SHALL be ignored.
REQ-036 ld_dly and set_dly SHALL never both be high in the same cycle.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 When rst=0: state=IDLE and every output = 0, including dly_out, ones_cnt and edge_dly.
REQ-039 Reset SHALL act asynchronously, with synchronous release through the clk flops; all internal counters and prev_maj are cleared.

Structure
REQ-040 The state encoding SHALL be defined as localparams in this module; the design needs no shared package.
REQ-041 The block SHALL be a single module with no sub-modules; it feeds odelay_fine_pipe (ld, set, delay) directly.

Verification
REQ-042 Scan first=0, last=40, step=8, dqs_sample=0 below code 20 and 1 from code 20: expect points 0, 8, 16, 24, 32, 40, edge_found=1, edge_dly=24, six ld_dly/set_dly pairs, one done.
REQ-043 first=250, last=255, step=8: expect a single point 250, done, and no wrap to a low code.
REQ-044 dly_ready low at start, high 10 cycles later: expect no ld_dly before that; then drop dly_ready mid-SAMPLE at cur=16: expect a re-LOAD of 16.
REQ-045 abort at cur=8 during SETTLE: expect busy=0 next cycle, no done, and dly_out=8 held.
REQ-046 NUM_SAMPLES=16 with dqs_sample high for exactly 8 cycles: expect ones_cnt=8 and maj=0 (tie); with 9 high cycles, maj=1 and an edge is recorded.
REQ-047 Assert rst during APPLY: expect all outputs to be 0 immediately, and a later start to run normally.
